// File: rtl/inst_cache_pkg.sv
// rtl/inst_cache_pkg.sv - shared types and constants for the instruction cache
// Purpose : FSM state encoding, address-segment constants and the bridge
//           address mapping used by inst_cache.
// Ports   : none (package).
package inst_cache_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   localparam logic [2:0] KSEG1     = 3'b101;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // kseg0/kseg1 fold onto the low 512 MB physical window; everything else
   // is passed through unchanged.
   function automatic logic [31:0] bridge_addr(input logic [31:2] a);
      if (a[31:30] == 2'b10) begin
         return {3'b000, a[28:2], 2'b00};
      end
      return {a, 2'b00};
   endfunction

endpackage

// File: rtl/icache_tagv.sv
// rtl/icache_tagv.sv - valid/tag/data storage for the direct-mapped instruction cache
// Purpose : one word per line; asynchronous read port, synchronous single
//           write port, valid bits cleared asynchronously by rst.
// Ports   : clk, rst                     clock, async active-high reset
//           rd_index -> rd_valid/rd_tag/rd_data   combinational lookup
//           we, wr_index, wr_tag, wr_data        line refill
module icache_tagv #(
   parameter int INDEX_WIDTH = 6,
   parameter int TAG_WIDTH   = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INDEX_WIDTH-1:0] rd_index,
   output logic                   rd_valid,
   output logic [TAG_WIDTH-1:0]   rd_tag,
   output logic [31:0]            rd_data,
   input  logic                   we,
   input  logic [INDEX_WIDTH-1:0] wr_index,
   input  logic [TAG_WIDTH-1:0]   wr_tag,
   input  logic [31:0]            wr_data
);

   localparam int LINES = 1 << INDEX_WIDTH;

   logic [LINES-1:0]     valid_q;
   logic [TAG_WIDTH-1:0] tag_mem  [LINES];
   logic [31:0]          data_mem [LINES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (we) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   // Tag and data need no reset: a line is only consulted when its valid bit is set.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped blocking instruction cache with sram-like bridge port
// Purpose : zero-latency hits from icache_tagv; misses and kseg1 fetches go
//           through IDLE -> REQ -> WAIT -> RESP with one outstanding transaction.
// Ports   : clk, rst                                   clock, async active-high reset
//           cpu_inst_en/wen/addr/wdata, cpu_longest_stall   CPU fetch side (wen/wdata unused)
//           cpu_inst_rdata, cpu_inst_stall             fetch result
//           cache_inst_req/wr/size/addr/wdata          bridge request
//           cache_inst_rdata/addr_ok/data_ok           bridge response
//           hit_cnt, miss_cnt                          performance counters
// Config  : ICACHE_PERF_EN enables the hit/miss counters; otherwise both read 0.
module inst_cache
   import inst_cache_pkg::*;
#(
   parameter int INDEX_WIDTH = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_inst_en,
   input  logic [3:0]  cpu_inst_wen,
   input  logic [31:0] cpu_inst_addr,
   input  logic [31:0] cpu_inst_wdata,
   input  logic        cpu_longest_stall,
   output logic [31:0] cpu_inst_rdata,
   output logic        cpu_inst_stall,
   output logic        cache_inst_req,
   output logic        cache_inst_wr,
   output logic [1:0]  cache_inst_size,
   output logic [31:0] cache_inst_addr,
   output logic [31:0] cache_inst_wdata,
   input  logic [31:0] cache_inst_rdata,
   input  logic        cache_inst_addr_ok,
   input  logic        cache_inst_data_ok,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);

   localparam int TAG_WIDTH = 30 - INDEX_WIDTH;

   state_t         state, state_nxt;
   logic [31:2]    addr_q;
   logic           cached_q;
   logic [31:0]    buf_q;

   logic                 rd_valid;
   logic [TAG_WIDTH-1:0] rd_tag;
   logic [31:0]          rd_data;
   logic                 cur_cached;
   logic                 hit;
   logic                 miss_start;
   logic                 buf_load;
   logic                 refill_we;
   logic                 unused_ok;

   assign unused_ok = &{1'b0, cpu_inst_wen, cpu_inst_wdata, cpu_inst_addr[1:0]};

   icache_tagv #(
      .INDEX_WIDTH(INDEX_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH)
   ) u_tagv (
      .clk     (clk),
      .rst     (rst),
      .rd_index(cpu_inst_addr[INDEX_WIDTH+1:2]),
      .rd_valid(rd_valid),
      .rd_tag  (rd_tag),
      .rd_data (rd_data),
      .we      (refill_we),
      .wr_index(addr_q[INDEX_WIDTH+1:2]),
      .wr_tag  (addr_q[31:INDEX_WIDTH+2]),
      .wr_data (cache_inst_rdata)
   );

   assign cur_cached = (cpu_inst_addr[31:29] != KSEG1);
   assign hit = (state == S_IDLE) && cpu_inst_en && cur_cached && rd_valid &&
                (rd_tag == cpu_inst_addr[31:INDEX_WIDTH+2]);

   assign cache_inst_wr    = 1'b0;
   assign cache_inst_size  = SIZE_WORD;
   assign cache_inst_wdata = '0;
   assign cache_inst_addr  = bridge_addr(addr_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         addr_q   <= '0;
         cached_q <= 1'b0;
         buf_q    <= '0;
      end else begin
         state <= state_nxt;
         if (miss_start) begin
            addr_q   <= cpu_inst_addr[31:2];
            cached_q <= cur_cached;
         end
         if (buf_load) begin
            buf_q <= cache_inst_rdata;
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      cpu_inst_rdata = rd_data;
      cpu_inst_stall = 1'b0;
      cache_inst_req = 1'b0;
      miss_start     = 1'b0;
      buf_load       = 1'b0;
      refill_we      = 1'b0;
      case (state)
         S_IDLE: begin
            // rst gating keeps stall low while reset is held with en asserted
            if (cpu_inst_en && !hit && !rst) begin
               cpu_inst_stall = 1'b1;
               miss_start     = 1'b1;
               state_nxt      = S_REQ;
            end
         end
         S_REQ: begin
            cpu_inst_stall = 1'b1;
            cache_inst_req = 1'b1;
            if (cache_inst_addr_ok) begin
               // data_ok together with addr_ok completes the transaction at once
               if (cache_inst_data_ok) begin
                  buf_load  = 1'b1;
                  refill_we = cached_q;
                  state_nxt = S_RESP;
               end else begin
                  state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cpu_inst_stall = 1'b1;
            if (cache_inst_data_ok) begin
               buf_load  = 1'b1;
               refill_we = cached_q;
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            cpu_inst_rdata = buf_q;
            if (!cpu_longest_stall) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_q, miss_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         if (hit) begin
            hit_q <= hit_q + 32'd1;
         end
         if (miss_start) begin
            miss_q <= miss_q + 32'd1;
         end
      end
   end

   assign hit_cnt  = hit_q;
   assign miss_cnt = miss_q;
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - self-checking bench for inst_cache
module tb_inst_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_inst_en;
   logic [3:0]  cpu_inst_wen;
   logic [31:0] cpu_inst_addr;
   logic [31:0] cpu_inst_wdata;
   logic        cpu_longest_stall;
   logic [31:0] cpu_inst_rdata;
   logic        cpu_inst_stall;
   logic        cache_inst_req;
   logic        cache_inst_wr;
   logic [1:0]  cache_inst_size;
   logic [31:0] cache_inst_addr;
   logic [31:0] cache_inst_wdata;
   logic [31:0] cache_inst_rdata;
   logic        cache_inst_addr_ok;
   logic        cache_inst_data_ok;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   inst_cache #(.INDEX_WIDTH(6)) dut (
      .clk               (clk),
      .rst               (rst),
      .cpu_inst_en       (cpu_inst_en),
      .cpu_inst_wen      (cpu_inst_wen),
      .cpu_inst_addr     (cpu_inst_addr),
      .cpu_inst_wdata    (cpu_inst_wdata),
      .cpu_longest_stall (cpu_longest_stall),
      .cpu_inst_rdata    (cpu_inst_rdata),
      .cpu_inst_stall    (cpu_inst_stall),
      .cache_inst_req    (cache_inst_req),
      .cache_inst_wr     (cache_inst_wr),
      .cache_inst_size   (cache_inst_size),
      .cache_inst_addr   (cache_inst_addr),
      .cache_inst_wdata  (cache_inst_wdata),
      .cache_inst_rdata  (cache_inst_rdata),
      .cache_inst_addr_ok(cache_inst_addr_ok),
      .cache_inst_data_ok(cache_inst_data_ok),
      .hit_cnt           (hit_cnt),
      .miss_cnt          (miss_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] bdata;
      int          aw;
      int          dw;
      logic        exp_hit;
      logic [31:0] exp_baddr;
      logic [31:0] exp_rdata;
      int          exp_stalls;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int exp_hits = 0;
   int exp_miss = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_counters(input string tag);
`ifdef ICACHE_PERF_EN
      chk({tag, "_hit_cnt"},  hit_cnt,  32'(exp_hits));
      chk({tag, "_miss_cnt"}, miss_cnt, 32'(exp_miss));
`else
      chk({tag, "_hit_cnt"},  hit_cnt,  32'd0);
      chk({tag, "_miss_cnt"}, miss_cnt, 32'd0);
`endif
   endtask

   // One fetch with a responsive bridge: addr_ok after aw extra REQ cycles,
   // data_ok dw cycles after the handshake (same cycle when dw==0). While
   // stalled the CPU address/en are scrambled; in RESP, hold cycles of
   // longest_stall are applied with spurious data_ok on the bridge.
   task automatic fetch(input string name, input logic [31:0] a, input logic [31:0] bdata,
                        input int aw, input int dw, input int hold,
                        output int stalls, output int reqs,
                        output logic [31:0] baddr, output logic [31:0] rdata);
      int ph, aw_cnt, dcnt, held;
      bit done;
      ph = 0; aw_cnt = 0; dcnt = 0; held = 0; done = 0;
      stalls = 0; reqs = 0; baddr = '0; rdata = '0;
      @(negedge clk);
      cpu_inst_en = 1'b1;
      cpu_inst_addr = a;
      cpu_longest_stall = 1'b0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         if (cyc > 0 && held == 0) begin
            cpu_inst_addr = a ^ 32'h4000_0F00;
            cpu_inst_en = 1'((cyc & 1) != 0);
         end
         cache_inst_addr_ok = 1'b0;
         cache_inst_data_ok = 1'b0;
         #1;
         if (ph != 0 && cache_inst_req) reqs++;
         if (ph == 0 && cache_inst_req) begin
            if (aw_cnt == aw) begin
               cache_inst_addr_ok = 1'b1;
               reqs++;
               baddr = cache_inst_addr;
               ph = 1;
               if (dw == 0) begin
                  cache_inst_data_ok = 1'b1;
                  cache_inst_rdata = bdata;
                  ph = 2;
               end
            end else begin
               aw_cnt++;
            end
         end else if (ph == 1) begin
            dcnt++;
            if (dcnt == dw) begin
               cache_inst_data_ok = 1'b1;
               cache_inst_rdata = bdata;
               ph = 2;
            end
         end else if (ph == 2 && held > 0) begin
            cache_inst_data_ok = 1'b1;
            cache_inst_rdata = 32'hDEAD_BEEF;
         end
         #1;
         if (!cpu_inst_stall) begin
            if (held == 0) rdata = cpu_inst_rdata;
            else chk($sformatf("%s_hold%0d_rdata", name, held), cpu_inst_rdata, rdata);
            if (held < hold) begin
               cpu_longest_stall = 1'b1;
               held++;
            end else begin
               cpu_longest_stall = 1'b0;
               done = 1;
            end
         end else begin
            stalls++;
         end
         if (!done) @(negedge clk);
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got stalled want completion", name);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[16];
      int          st, rq;
      logic [31:0] ba, rd;

      vecs[0]  = '{32'h8000_0010, 32'h2402_0001, 0, 2, 1'b0, 32'h0000_0010, 32'h2402_0001, 4};
      vecs[1]  = '{32'h8000_0010, 32'hEEEE_EEEE, 0, 0, 1'b1, 32'h0000_0000, 32'h2402_0001, 0};
      vecs[2]  = '{32'hBFC0_0000, 32'h3C08_BFC0, 0, 0, 1'b0, 32'h1FC0_0000, 32'h3C08_BFC0, 2};
      vecs[3]  = '{32'hBFC0_0000, 32'h3C08_BFC1, 1, 1, 1'b0, 32'h1FC0_0000, 32'h3C08_BFC1, 4};
      vecs[4]  = '{32'hA000_0010, 32'h5555_AAAA, 0, 1, 1'b0, 32'h0000_0010, 32'h5555_AAAA, 3};
      vecs[5]  = '{32'h8000_0010, 32'hEEEE_EEEE, 0, 0, 1'b1, 32'h0000_0000, 32'h2402_0001, 0};
      vecs[6]  = '{32'h8000_0110, 32'h2403_0002, 0, 1, 1'b0, 32'h0000_0110, 32'h2403_0002, 3};
      vecs[7]  = '{32'h8000_0110, 32'hEEEE_EEEE, 0, 0, 1'b1, 32'h0000_0000, 32'h2403_0002, 0};
      vecs[8]  = '{32'h8000_0010, 32'h2402_0001, 2, 0, 1'b0, 32'h0000_0010, 32'h2402_0001, 4};
      vecs[9]  = '{32'h8000_0010, 32'hEEEE_EEEE, 0, 0, 1'b1, 32'h0000_0000, 32'h2402_0001, 0};
      vecs[10] = '{32'h9FC0_0004, 32'h1234_5678, 0, 0, 1'b0, 32'h1FC0_0004, 32'h1234_5678, 2};
      vecs[11] = '{32'h0040_0008, 32'hCAFE_0001, 0, 3, 1'b0, 32'h0040_0008, 32'hCAFE_0001, 5};
      vecs[12] = '{32'h0040_000B, 32'hEEEE_EEEE, 0, 0, 1'b1, 32'h0000_0000, 32'hCAFE_0001, 0};
      vecs[13] = '{32'hC000_000C, 32'h7777_000C, 0, 0, 1'b0, 32'hC000_000C, 32'h7777_000C, 2};
      vecs[14] = '{32'hC000_000E, 32'hEEEE_EEEE, 0, 0, 1'b1, 32'h0000_0000, 32'h7777_000C, 0};
      vecs[15] = '{32'h9FC0_0004, 32'hEEEE_EEEE, 0, 0, 1'b1, 32'h0000_0000, 32'h1234_5678, 0};

      rst = 1'b1;
      cpu_inst_en = 1'b1;
      cpu_inst_wen = 4'hF;
      cpu_inst_addr = 32'h8000_0010;
      cpu_inst_wdata = 32'hFFFF_FFFF;
      cpu_longest_stall = 1'b0;
      cache_inst_rdata = '0;
      cache_inst_addr_ok = 1'b0;
      cache_inst_data_ok = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", {31'd0, cpu_inst_stall}, 32'd0);
      chk("rst_req", {31'd0, cache_inst_req}, 32'd0);
      chk("rst_wr", {31'd0, cache_inst_wr}, 32'd0);
      chk("rst_size", {30'd0, cache_inst_size}, 32'd2);
      chk("rst_wdata", cache_inst_wdata, 32'd0);
      chk("rst_hit_cnt", hit_cnt, 32'd0);
      chk("rst_miss_cnt", miss_cnt, 32'd0);
      cpu_inst_en = 1'b0;
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         fetch($sformatf("v%0d", i), vecs[i].addr, vecs[i].bdata, vecs[i].aw, vecs[i].dw, 0,
               st, rq, ba, rd);
         if (vecs[i].exp_hit) exp_hits++;
         else exp_miss++;
         chk($sformatf("v%0d_stalls", i), 32'(st), 32'(vecs[i].exp_stalls));
         chk($sformatf("v%0d_reqs", i), 32'(rq), vecs[i].exp_hit ? 32'd0 : 32'd1);
         chk($sformatf("v%0d_baddr", i), ba, vecs[i].exp_baddr);
         chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      end
      @(negedge clk);
      cpu_inst_en = 1'b0;
      #1;
      check_counters("tbl");

      // RESP held by longest_stall for 3 cycles, then IDLE immediately after release
      fetch("hold", 32'h8000_0020, 32'hABCD_0001, 0, 1, 3, st, rq, ba, rd);
      exp_miss++;
      chk("hold_stalls", 32'(st), 32'd3);
      chk("hold_rdata", rd, 32'hABCD_0001);
      chk("hold_baddr", ba, 32'h0000_0020);
      fetch("after_hold", 32'h8000_0030, 32'h1357_9BDF, 0, 0, 0, st, rq, ba, rd);
      exp_miss++;
      chk("after_hold_stalls", 32'(st), 32'd2);
      chk("after_hold_rdata", rd, 32'h1357_9BDF);
      fetch("hold_hit", 32'h8000_0020, 32'hEEEE_EEEE, 0, 0, 0, st, rq, ba, rd);
      exp_hits++;
      chk("hold_hit_stalls", 32'(st), 32'd0);
      chk("hold_hit_rdata", rd, 32'hABCD_0001);

      // Reset while waiting for data; late data_ok must not refill anything
      @(negedge clk);
      cpu_inst_en = 1'b1;
      cpu_inst_addr = 32'h8000_0040;
      cache_inst_addr_ok = 1'b0;
      cache_inst_data_ok = 1'b0;
      #1;
      chk("b_idle_stall", {31'd0, cpu_inst_stall}, 32'd1);
      @(negedge clk);
      cache_inst_addr_ok = 1'b1;
      #1;
      chk("b_req", {31'd0, cache_inst_req}, 32'd1);
      chk("b_req_addr", cache_inst_addr, 32'h0000_0040);
      @(negedge clk);
      cache_inst_addr_ok = 1'b0;
      cpu_inst_en = 1'b0;
      #1;
      chk("b_wait_req", {31'd0, cache_inst_req}, 32'd0);
      chk("b_wait_stall", {31'd0, cpu_inst_stall}, 32'd1);
      rst = 1'b1;
      #1;
      exp_hits = 0;
      exp_miss = 0;
      chk("b_rst_stall", {31'd0, cpu_inst_stall}, 32'd0);
      chk("b_rst_req", {31'd0, cache_inst_req}, 32'd0);
      check_counters("b_rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      cache_inst_data_ok = 1'b1;
      cache_inst_rdata = 32'hFFFF_0000;
      @(negedge clk);
      cache_inst_data_ok = 1'b0;

      fetch("b_refetch", 32'h8000_0040, 32'h0404_0404, 0, 0, 0, st, rq, ba, rd);
      exp_miss++;
      chk("b_refetch_stalls", 32'(st), 32'd2);
      chk("b_refetch_reqs", 32'(rq), 32'd1);
      chk("b_refetch_rdata", rd, 32'h0404_0404);
      fetch("b_cold", 32'h8000_0010, 32'h2402_0001, 0, 0, 0, st, rq, ba, rd);
      exp_miss++;
      chk("b_cold_stalls", 32'(st), 32'd2);
      chk("b_cold_rdata", rd, 32'h2402_0001);
      fetch("b_hit", 32'h8000_0040, 32'hEEEE_EEEE, 0, 0, 0, st, rq, ba, rd);
      exp_hits++;
      chk("b_hit_stalls", 32'(st), 32'd0);
      chk("b_hit_rdata", rd, 32'h0404_0404);
      @(negedge clk);
      cpu_inst_en = 1'b0;
      #1;
      check_counters("end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inst_cache.md
INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 Parameter: INDEX_WIDTH, default 6, log2 of line count; one 32-bit word per line, direct-mapped.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cpu_inst_en / cpu_inst_wen / cpu_inst_addr / cpu_inst_wdata  in  1/4/32/32  CPU fetch request; wen and wdata ignored.
REQ-005 cpu_longest_stall  in  1  CPU pipeline frozen this cycle.
REQ-006 cpu_inst_rdata  out  32  fetched word.
REQ-007 cpu_inst_stall  out  1  fetch not yet satisfied.
REQ-008 cache_inst_req / cache_inst_wr / cache_inst_size / cache_inst_addr / cache_inst_wdata  out  1/1/2/32/32  sram-like request to bridge.
REQ-009 cache_inst_rdata / cache_inst_addr_ok / cache_inst_data_ok  in  32/1/1  sram-like response from bridge.
REQ-010 hit_cnt / miss_cnt  out  32/32  performance counters (see Configuration).

Function
REQ-011 Address split: index = addr[INDEX_WIDTH+1:2], tag = addr[31:INDEX_WIDTH+2]; addr[1:0] ignored.
REQ-012 Uncached when addr[31:29]==3'b101 (kseg1); uncached fetches never read or write the array.
REQ-013 Bridge address: addr[31:30]==2'b10 -> {3'b000, addr[28:2], 2'b00}, else {addr[31:2], 2'b00}.
REQ-014 Bridge request fields constant: wr=0, size=2'b10, wdata=0.
REQ-015 States IDLE, REQ, WAIT, RESP; reset state IDLE.
REQ-016 IDLE, en=1, cached, valid and tag match (hit): stall=0, rdata = array word combinationally, stay IDLE, zero latency.
REQ-017 IDLE, en=1, miss or uncached: stall=1, latch address and cached flag, go REQ next cycle.
REQ-018 REQ: req=1 with latched address; addr_ok=1 -> WAIT; addr_ok and data_ok same cycle -> treat as WAIT completion, go RESP.
REQ-019 WAIT: req=0; data_ok=1 -> capture rdata into buffer, refill line (data, tag, valid=1) if cached, go RESP.
REQ-020 stall=1 in REQ and WAIT regardless of en or address changes; latched address governs.
REQ-021 RESP: stall=0, cpu_inst_rdata = buffer; return to IDLE when cpu_longest_stall=0, otherwise hold RESP with buffer stable.
REQ-022 data_ok in IDLE or RESP is ignored; no more than one outstanding bridge transaction.
REQ-023 en=0 in IDLE: stall=0, req=0, no state change, rdata don't-care.

Reset
REQ-024 rst asserted: state IDLE, all valid bits 0, req=0, stall=0, rdata buffer 0, counters 0, effective immediately.
REQ-025 Reset mid-miss abandons the transaction; a data_ok arriving after reset is ignored and nothing is refilled.

Configuration
REQ-026 Macro ICACHE_PERF_EN defined: hit_cnt increments per REQ-016 hit, miss_cnt per IDLE->REQ transition, 32-bit wrapping.
REQ-027 Macro undefined: hit_cnt and miss_cnt tied to 0, no counter flops.

Structure
REQ-028 Shared package: state encoding typedef, KSEG1 prefix 3'b101, SIZE_WORD 2'b10.
REQ-029 One sub-module icache_tagv: valid/tag/data arrays, async read, synchronous single-port write, async valid clear.

Verification
REQ-030 Cold fetch 0x8000_0010, bridge addr_ok 1 cycle, data_ok 3 cycles later with 0x2402_0001 -> bridge addr 0x0000_0010, stall 4 cycles, RESP rdata 0x2402_0001, miss_cnt=1.
REQ-031 Refetch 0x8000_0010 -> stall=0 same cycle, rdata 0x2402_0001, no req, hit_cnt=1.
REQ-032 Fetch 0xBFC0_0000 twice -> two bridge requests to 0x1FC0_0000, no hit, array unchanged.
REQ-033 Conflict: 0x8000_0010 then 0x8000_0110 (INDEX_WIDTH=6) -> second misses, replaces line, then 0x8000_0010 misses again.
REQ-034 data_ok arrives with cpu_longest_stall=1 for 3 cycles -> RESP held, rdata stable, IDLE on first cycle longest_stall=0.
REQ-035 rst pulsed during WAIT, later data_ok -> state IDLE, req=0, next fetch of same address misses.
